alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 48 ++++
 rtl/alu_arbiter.sv | 98 +++++++++
 tb/tb_alu_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester/response channels plus the shared ALU port of alu_arbiter.
// master = requester/ALU side (testbench or fabric), slave = the arbiter itself.
interface alu_arbiter_if #(
    parameter int XLEN = 32
);
    logic            req0_valid;
    logic            req0_ready;
    logic [XLEN-1:0] req0_a;
    logic [XLEN-1:0] req0_b;
    logic [6:0]      req0_opcode;
    logic [2:0]      req0_funct3;
    logic [6:0]      req0_funct7;
    logic            req1_valid;
    logic            req1_ready;
    logic [XLEN-1:0] req1_a;
    logic [XLEN-1:0] req1_b;
    logic [6:0]      req1_opcode;
    logic [2:0]      req1_funct3;
    logic [6:0]      req1_funct7;
    logic            rsp0_valid;
    logic            rsp0_ready;
    logic [XLEN-1:0] rsp0_result;
    logic            rsp1_valid;
    logic            rsp1_ready;
    logic [XLEN-1:0] rsp1_result;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [6:0]      alu_opcode;
    logic [2:0]      alu_funct3;
    logic [6:0]      alu_funct7;
    logic [XLEN-1:0] alu_result;

    modport master (
        output req0_valid, req0_a, req0_b, req0_opcode, req0_funct3, req0_funct7,
        output req1_valid, req1_a, req1_b, req1_opcode, req1_funct3, req1_funct7,
        output rsp0_ready, rsp1_ready, alu_result,
        input  req0_ready, req1_ready, rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
        input  alu_a, alu_b, alu_opcode, alu_funct3, alu_funct7
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_opcode, req0_funct3, req0_funct7,
        input  req1_valid, req1_a, req1_b, req1_opcode, req1_funct3, req1_funct7,
        input  rsp0_ready, rsp1_ready, alu_result,
        output req0_ready, req1_ready, rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
        output alu_a, alu_b, alu_opcode, alu_funct3, alu_funct7
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU: IDLE -> EXEC -> RESP, one op in flight.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
//
// state | meaning
// IDLE  | waiting for a request; ready driven to the granted requester
// EXEC  | registered operands drive the ALU; result captured
// RESP  | result presented to the granted requester until it is consumed
module alu_arbiter #(
    parameter int XLEN = 32
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] a_q, b_q, result_q;
    logic [6:0]      opcode_q, funct7_q;
    logic [2:0]      funct3_q;
    logic            grant_q;
    logic            arb_g;
    logic            hs;
    logic            req0_ready, req1_ready;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign arb_g = ~bus.req0_valid;
`else
    logic last_q;
    // On a tie the requester not served last wins; otherwise whoever is valid.
    assign arb_g = (bus.req0_valid && bus.req1_valid) ? ~last_q : ~bus.req0_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     last_q <= 1'b1;
        else if (hs) last_q <= arb_g;
    end
`endif

    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        hs         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((bus.req0_valid || bus.req1_valid) && !rst) begin
                    req0_ready = ~arb_g;
                    req1_ready = arb_g;
                    hs         = 1'b1;
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: state_d = S_RESP;
            S_RESP: begin
                if (grant_q ? bus.rsp1_ready : bus.rsp0_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            opcode_q <= '0;
            funct3_q <= '0;
            funct7_q <= '0;
            grant_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                grant_q  <= arb_g;
                a_q      <= arb_g ? bus.req1_a      : bus.req0_a;
                b_q      <= arb_g ? bus.req1_b      : bus.req0_b;
                opcode_q <= arb_g ? bus.req1_opcode : bus.req0_opcode;
                funct3_q <= arb_g ? bus.req1_funct3 : bus.req0_funct3;
                funct7_q <= arb_g ? bus.req1_funct7 : bus.req0_funct7;
            end
            if (state_q == S_EXEC) result_q <= bus.alu_result;
        end
    end

    // Fields only change on entry to EXEC, so outside EXEC the ALU inputs hold their last values.
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.alu_opcode  = opcode_q;
    assign bus.alu_funct3  = funct3_q;
    assign bus.alu_funct7  = funct7_q;

    assign bus.req0_ready  = req0_ready;
    assign bus.req1_ready  = req1_ready;
    assign bus.rsp0_valid  = (state_q == S_RESP) && !grant_q;
    assign bus.rsp1_valid  = (state_q == S_RESP) && grant_q;
    assign bus.rsp0_result = grant_q ? '0 : result_q;
    assign bus.rsp1_result = grant_q ? result_q : '0;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: table of tie/single ops plus backpressure and mid-op reset sequences.
// The ALU is modelled here as a small combinational RV32 subset.
module tb_alu_arbiter;
    localparam int XLEN = 32;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.XLEN(XLEN)) bus ();
    alu_arbiter #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always_comb begin
        bus.alu_result = '0;
        if (bus.alu_opcode == OP_LUI) bus.alu_result = bus.alu_b;
        else if (bus.alu_opcode == OP_R) begin
            case (bus.alu_funct3)
                3'd0: bus.alu_result = bus.alu_funct7[5] ? bus.alu_a - bus.alu_b : bus.alu_a + bus.alu_b;
                3'd4: bus.alu_result = bus.alu_a ^ bus.alu_b;
                3'd5: bus.alu_result = bus.alu_funct7[5] ? $unsigned($signed(bus.alu_a) >>> bus.alu_b[4:0])
                                                         : bus.alu_a >> bus.alu_b[4:0];
                3'd6: bus.alu_result = bus.alu_a | bus.alu_b;
                3'd7: bus.alu_result = bus.alu_a & bus.alu_b;
                default: bus.alu_result = '0;
            endcase
        end
    end

    typedef struct {
        logic        v0;
        logic [31:0] a0, b0;
        logic [2:0]  f30;
        logic [6:0]  op0, f70;
        logic        v1;
        logic [31:0] a1, b1;
        logic [2:0]  f31;
        logic [6:0]  op1, f71;
        logic [31:0] exp0, exp1;
    } vec_t;

    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;
    logic last_g;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.req0_valid = v.v0;  bus.req0_a = v.a0;  bus.req0_b = v.b0;
        bus.req0_opcode = v.op0; bus.req0_funct3 = v.f30; bus.req0_funct7 = v.f70;
        bus.req1_valid = v.v1;  bus.req1_a = v.a1;  bus.req1_b = v.b1;
        bus.req1_opcode = v.op1; bus.req1_funct3 = v.f31; bus.req1_funct7 = v.f71;
    endtask

    function automatic logic model_grant(input logic v0, input logic v1);
`ifdef ALU_ARB_FIXED_PRIO_EN
        return !v0;
`else
        return (v0 && v1) ? !last_g : !v0;
`endif
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
    task automatic run_vec(input vec_t v, input string tag);
        logic        g;
        logic [31:0] exp_r, exp_a;
        g     = model_grant(v.v0, v.v1);
        exp_r = g ? v.exp1 : v.exp0;
        exp_a = g ? v.a1 : v.a0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        drive(v);
        #1;
        chk({tag, " idle rsp_valid"}, {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        chk({tag, " grant ready"}, {30'd0, bus.req1_ready, bus.req0_ready}, g ? 32'd2 : 32'd1);
        @(negedge clk);
        chk({tag, " exec ready"}, {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        chk({tag, " exec rsp_valid"}, {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        chk({tag, " exec alu_a"}, bus.alu_a, exp_a);
        @(negedge clk);
        chk({tag, " resp rsp_valid"}, {30'd0, bus.rsp1_valid, bus.rsp0_valid}, g ? 32'd2 : 32'd1);
        chk({tag, " resp result"}, g ? bus.rsp1_result : bus.rsp0_result, exp_r);
        chk({tag, " other result"}, g ? bus.rsp0_result : bus.rsp1_result, 32'd0);
        last_g = g;
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'd33, 32'd5, 3'd0, OP_R, 7'h20,
                    1'b1, 32'd0, 32'h12345000, 3'd0, OP_LUI, 7'h00, 32'd28, 32'h12345000};
        vecs[1] = vecs[0];
        vecs[2] = '{1'b1, 32'd100, 32'd23, 3'd0, OP_R, 7'h00,
                    1'b1, 32'hFF00FF00, 32'h0F0F0F0F, 3'd4, OP_R, 7'h00, 32'd123, 32'hF00FF00F};
        vecs[3] = '{1'b1, 32'hFFFF0000, 32'h12345678, 3'd7, OP_R, 7'h00,
                    1'b1, 32'h000000F0, 32'h0000000F, 3'd6, OP_R, 7'h00, 32'h12340000, 32'h000000FF};
        vecs[4] = '{1'b1, 32'd0, 32'd1, 3'd0, OP_R, 7'h20,
                    1'b1, 32'hFFFFFFFF, 32'd2, 3'd0, OP_R, 7'h00, 32'hFFFFFFFF, 32'h00000001};
        vecs[5] = '{1'b1, 32'h80000000, 32'd4, 3'd5, OP_R, 7'h00,
                    1'b1, 32'h80000000, 32'd4, 3'd5, OP_R, 7'h20, 32'h08000000, 32'hF8000000};
        vecs[6] = '{1'b0, 32'd0, 32'd0, 3'd0, OP_R, 7'h00,
                    1'b1, 32'd0, 32'hABCDE000, 3'd0, OP_LUI, 7'h00, 32'd0, 32'hABCDE000};
        vecs[7] = '{1'b1, 32'd33, 32'd5, 3'd0, OP_R, 7'h00,
                    1'b0, 32'd0, 32'd0, 3'd0, OP_R, 7'h00, 32'd38, 32'd0};

        // Reset with both requesters valid: nothing may be accepted.
        drive(vecs[0]);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        last_g = 1'b1;
        #12;
        chk("reset ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        chk("reset rsp_valid", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        chk("reset alu_a", bus.alu_a, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure on requester 1 for 5 cycles while requester 0 keeps asking.
        drive(vecs[6]);
        bus.req1_a = 32'hF0F0F0F0; bus.req1_b = 32'd16;
        bus.req1_opcode = OP_R; bus.req1_funct3 = 3'd5; bus.req1_funct7 = 7'h20;
        bus.rsp1_ready = 1'b0;
        #1;
        chk("bp grant", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd2);
        @(negedge clk);
        bus.req0_valid = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp valid c%0d", c), {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd2);
            chk($sformatf("bp result c%0d", c), bus.rsp1_result, 32'hFFFFF0F0);
            chk($sformatf("bp ready c%0d", c), {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
            @(negedge clk);
        end
        bus.rsp1_ready = 1'b1;
        @(negedge clk);
        chk("bp released", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        last_g = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);

        // Reset asserted during EXEC aborts the op; next tie goes to requester 0.
        drive(vecs[0]);
        @(negedge clk);
        chk("pre-reset exec alu_a", bus.alu_a, 32'd33);
        rst = 1'b1;
        #1;
        chk("mid reset alu_a", bus.alu_a, 32'd0);
        chk("mid reset ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        chk("mid reset rsp", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        last_g = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("post reset rsp c%0d", c), {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        end
        run_vec(vecs[0], "after reset tie");

        drive(vecs[7]);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
